dtree_seq_engine: RTL and testbench
===================================

DTREE_SEQ_ENGINE -- requirements
Module: dtree_seq_engine

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  N_FEAT, 5, number of input features
  FEAT_W, 8, feature width in bits
  NODE_AW, 6, node address width (2**NODE_AW nodes)
  CLASS_W, 6, leaf class width
  MAX_DEPTH, 16, maximum nodes visited per inference
REQ-002 SHALL have ports, one per line: name, direction, width, meaning (FI_W = clog2(N_FEAT), SH_W = clog2(FEAT_W), NODE_W = 1+FI_W+SH_W+FEAT_W+2*NODE_AW):
  clk  in  1  single clock; all state updates on its rising edge
  rst  in  1  reset, asynchronous, active-high
  in_valid  in  1  feature vector valid
  in_ready  out  1  engine can accept a vector
  in_feat  in  N_FEAT*FEAT_W  features; feature i at bits [i*FEAT_W +: FEAT_W]
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  out_class  out  CLASS_W  predicted class
  out_depth  out  clog2(MAX_DEPTH+1)  nodes visited, leaf included
  out_err  out  1  depth limit hit before reaching a leaf
  cfg_we  in  1  node table write strobe
  cfg_addr  in  NODE_AW  node index
  cfg_data  in  NODE_W  node word
  busy  out  1  high when the state is not IDLE
REQ-003 Node word, MSB first: is_leaf(1), feat_idx(FI_W), shift(SH_W), thresh(FEAT_W), left(NODE_AW), right(NODE_AW); for a leaf, class = bits [CLASS_W-1:0] and all other fields are ignored.

Function
REQ-004 Node table SHALL be a 2**NODE_AW x NODE_W register array, read combinationally, written only by cfg_we.
REQ-005 cfg_we SHALL take effect at the clock edge only when the state is IDLE; a write in any other state is dropped, with no side effect.
REQ-006 FSM states SHALL be IDLE, WALK, DONE.
REQ-007 IDLE: in_ready=1; when in_valid is high at an edge, the engine latches in_feat, sets ptr=0 and steps=0, and moves to WALK.
REQ-008 WALK: in_ready=0; each edge evaluates node[ptr] once (one node per cycle).
REQ-009 Internal-node test SHALL be (feature[feat_idx] >> shift) <= thresh, as an unsigned compare on FEAT_W bits. True selects left, false selects right. The compare result alone selects the child; no other logic modifies that selection.
REQ-010 Internal node: ptr <= child and steps <= steps+1. When steps+1 == MAX_DEPTH, the engine goes to DONE with out_err=1, out_class=0, out_depth=MAX_DEPTH.
REQ-011 Leaf node: the engine goes to DONE with out_class=leaf class, out_depth=steps+1, out_err=0.
REQ-012 A feat_idx >= N_FEAT SHALL read as feature value 0.
REQ-013 DONE: out_valid=1 and the outputs are held stable until out_ready is high at an edge; the engine then returns to IDLE.
REQ-014 Latency: for a path of k nodes (k <= MAX_DEPTH, including the leaf), out_valid rises k edges after the acceptance edge.
REQ-015 Throughput SHALL be one inference in flight; a new vector is accepted no earlier than the edge after the DONE->IDLE edge.
REQ-016 A self-loop or cycle in the table SHALL terminate via REQ-010 and SHALL NOT hang the engine.
REQ-017 in_feat changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-018 rst high SHALL immediately force, with no clock edge required: state=IDLE, out_valid=0, out_class=0, out_depth=0, out_err=0, busy=0, in_ready=1.
REQ-019 rst SHALL clear every node word to 0. A zero word is an internal node that self-loops, so inference after reset with no configuration yields out_err=1.
REQ-020 rst asserted mid-WALK or in DONE SHALL abort the inference; no out_valid is produced for it.

Verification
REQ-021 Reset, no config; in_feat=0, in_valid=1 -> out_valid 16 edges after acceptance, out_err=1, out_class=0, out_depth=16.
REQ-022 Load node0 = {internal, feat_idx=0, shift=2, thresh=5, left=1, right=2}, node1 = leaf class 3, node2 = leaf class 9. X0=23 (23>>2=5) -> class 3, depth 2, 2 edges. X0=24 (24>>2=6) -> class 9, depth 2.
REQ-023 Backpressure: out_ready held low for 5 cycles -> out_valid, out_class and out_depth stable throughout, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-024 cfg_we asserted during WALK with cfg_addr=1 -> the current and next results still use the old node1.
REQ-025 rst asserted for 1 cycle mid-WALK -> out_valid stays 0 and busy=0 immediately; the table is cleared, so the next inference returns out_err=1.
REQ-026 Boundary compare: feature=255, shift=0, thresh=255 -> left; thresh=254 -> right. feat_idx=7 with N_FEAT=5 -> value 0, so thresh=0 -> left.

Source files
------------

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree inference engine. It walks a configurable node table
// one node per clock and reports the leaf class it reaches, or a depth-limit error.
module dtree_seq_engine #(
    parameter int N_FEAT    = 5,
    parameter int FEAT_W    = 8,
    parameter int NODE_AW   = 6,
    parameter int CLASS_W   = 6,
    parameter int MAX_DEPTH = 16,
    localparam int FI_W     = $clog2(N_FEAT),
    localparam int SH_W     = $clog2(FEAT_W),
    localparam int NODE_W   = 1 + FI_W + SH_W + FEAT_W + 2*NODE_AW,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic [DEPTH_W-1:0]       out_depth,
    output logic                     out_err,
    input  logic                     cfg_we,
    input  logic [NODE_AW-1:0]       cfg_addr,
    input  logic [NODE_W-1:0]        cfg_data,
    output logic                     busy
);

    localparam int R_LSB    = 0;
    localparam int L_LSB    = NODE_AW;
    localparam int TH_LSB   = 2*NODE_AW;
    localparam int SH_LSB   = TH_LSB + FEAT_W;
    localparam int FI_LSB   = SH_LSB + SH_W;
    localparam int LEAF_BIT = NODE_W - 1;
    localparam int N_NODES  = 2**NODE_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [NODE_AW-1:0]         ptr_q, ptr_d;
    logic [DEPTH_W-1:0]         steps_q, steps_d;
    logic                       out_valid_q, out_valid_d;
    logic [CLASS_W-1:0]         out_class_q, out_class_d;
    logic [DEPTH_W-1:0]         out_depth_q, out_depth_d;
    logic                       out_err_q, out_err_d;
    logic                       in_ready_q, in_ready_d;
    logic                       busy_q, busy_d;
    logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;

    logic [NODE_W-1:0]          node_q [N_NODES];
    logic                       tbl_we;

    logic [NODE_W-1:0]          cur_node;
    logic                       cur_leaf;
    logic [FI_W-1:0]            cur_fidx;
    logic [SH_W-1:0]            cur_shift;
    logic [FEAT_W-1:0]          cur_thresh;
    logic [NODE_AW-1:0]         cur_left;
    logic [NODE_AW-1:0]         cur_right;
    logic [CLASS_W-1:0]         cur_class;
    logic [FEAT_W-1:0]          feat_sel;
    logic                       go_left;
    logic [DEPTH_W-1:0]         steps_inc;

    // Table writes are only honoured while no inference is in flight.
    assign tbl_we = cfg_we && (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                node_q[i] <= '0;
            end
        end else if (tbl_we) begin
            node_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        cur_node   = node_q[ptr_q];
        cur_leaf   = cur_node[LEAF_BIT];
        cur_fidx   = cur_node[FI_LSB +: FI_W];
        cur_shift  = cur_node[SH_LSB +: SH_W];
        cur_thresh = cur_node[TH_LSB +: FEAT_W];
        cur_left   = cur_node[L_LSB +: NODE_AW];
        cur_right  = cur_node[R_LSB +: NODE_AW];
        cur_class  = cur_node[CLASS_W-1:0];
    end

    // Out-of-range feature indices fall through the loop and read as zero.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (cur_fidx == FI_W'(i)) begin
                feat_sel = feat_q[i*FEAT_W +: FEAT_W];
            end
        end
    end

    assign go_left   = (feat_sel >> cur_shift) <= cur_thresh;
    assign steps_inc = steps_q + DEPTH_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        steps_d     = steps_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_depth_d = out_depth_q;
        out_err_d   = out_err_q;
        feat_d      = feat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_WALK;
                    ptr_d   = '0;
                    steps_d = '0;
                    feat_d  = in_feat;
                end
            end
            S_WALK: begin
                if (cur_leaf) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_class_d = cur_class;
                    out_depth_d = steps_inc;
                    out_err_d   = 1'b0;
                end else if (steps_inc == DEPTH_W'(MAX_DEPTH)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_class_d = '0;
                    out_depth_d = DEPTH_W'(MAX_DEPTH);
                    out_err_d   = 1'b1;
                end else begin
                    ptr_d   = go_left ? cur_left : cur_right;
                    steps_d = steps_inc;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            steps_q     <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_depth_q <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            steps_q     <= steps_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_depth_q <= out_depth_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Captured feature vector is pure data, so it carries no reset.
    always_ff @(posedge clk) begin
        feat_q <= feat_d;
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_depth = out_depth_q;
    assign out_err   = out_err_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Randomized scoreboard bench for dtree_seq_engine against a table-walking reference model.
module tb_dtree_seq_engine;

    localparam int N_FEAT    = 5;
    localparam int FEAT_W    = 8;
    localparam int NODE_AW   = 6;
    localparam int CLASS_W   = 6;
    localparam int MAX_DEPTH = 16;
    localparam int NODE_W    = 27;
    localparam int DEPTH_W   = 5;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic [DEPTH_W-1:0]       out_depth;
    logic                     out_err;
    logic                     cfg_we;
    logic [NODE_AW-1:0]       cfg_addr;
    logic [NODE_W-1:0]        cfg_data;
    logic                     busy;

    dtree_seq_engine #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW),
        .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_depth(out_depth), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
    );

    typedef struct {
        int cls;
        int dep;
        int err;
        int acc;
    } exp_t;

    exp_t            sb[$];
    logic [26:0]     ref_tbl [64];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    bit              seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [26:0] mk_leaf(input int c);
        return 27'(c & 63) | (27'(1) << 26);
    endfunction

    function automatic logic [26:0] mk_int(input int fi, input int sh, input int th,
                                           input int l, input int r);
        return 27'(((fi & 7) << 23) | ((sh & 7) << 20) | ((th & 255) << 12) |
                   ((l & 63) << 6) | (r & 63));
    endfunction

    // Reference: follow the tree from node 0 for at most MAX_DEPTH nodes.
    function automatic exp_t model(input logic [39:0] f);
        exp_t e;
        int   p = 0;
        for (int d = 1; d <= MAX_DEPTH; d++) begin
            int w;
            int fi, sh, th, l, r, v;
            w  = int'(ref_tbl[p]);
            if (((w >> 26) & 1) == 1) begin
                e.cls = w & 63;
                e.dep = d;
                e.err = 0;
                e.acc = 0;
                return e;
            end
            fi = (w >> 23) & 7;
            sh = (w >> 20) & 7;
            th = (w >> 12) & 255;
            l  = (w >> 6) & 63;
            r  = w & 63;
            v  = (fi < N_FEAT) ? int'((f >> (fi * 8)) & 40'hFF) : 0;
            p  = ((v >> sh) <= th) ? l : r;
        end
        e.cls = 0;
        e.dep = MAX_DEPTH;
        e.err = 1;
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic cfg_write(input int a, input logic [26:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 6'(a);
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        ref_tbl[a] = d;
    endtask

    task automatic run(input logic [39:0] f, input int hold, input bit wr_walk);
        exp_t e;
        int   n;
        in_feat   = f;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e     = model(f);
        e.acc = cyc;
        sb.push_back(e);
        in_feat = {$urandom, 8'($urandom)};
        if (wr_walk) begin
            cfg_we   = 1'b1;
            cfg_addr = 6'd1;
            cfg_data = mk_leaf(7);
            @(posedge clk); #1;
            cfg_we   = 1'b0;
        end
        n = 0;
        while (!out_valid && n < MAX_DEPTH + 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            sb.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_done", int'(in_ready), 1);
        chk("out_valid_after_done", int'(out_valid), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    // Monitor: compare the presented result against the scoreboard head every valid cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected 0");
            end else begin
                if (!seen) begin
                    checks++;
                    if (cyc - sb[0].acc != sb[0].dep) begin
                        errors++;
                        $display("FAIL latency: got %0d edges expected %0d",
                                 cyc - sb[0].acc, sb[0].dep);
                    end
                    seen = 1'b1;
                end
                checks++;
                if (out_class !== 6'(sb[0].cls) || out_depth !== 5'(sb[0].dep) ||
                    out_err !== 1'(sb[0].err)) begin
                    errors++;
                    $display("FAIL result: got class=%0d depth=%0d err=%0d expected class=%0d depth=%0d err=%0d",
                             out_class, out_depth, out_err, sb[0].cls, sb[0].dep, sb[0].err);
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_handshake: got in_ready=%0d busy=%0d expected 0 1",
                             in_ready, busy);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        for (int i = 0; i < 64; i++) ref_tbl[i] = '0;
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_class", int'(out_class), 0);
        chk("reset_out_depth", int'(out_depth), 0);
        chk("reset_out_err", int'(out_err), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Unconfigured table self-loops at node 0 until the depth limit.
        run(40'd0, 0, 1'b0);

        cfg_write(0, mk_int(0, 2, 5, 1, 2));
        cfg_write(1, mk_leaf(3));
        cfg_write(2, mk_leaf(9));
        run(40'd23, 0, 1'b0);
        run(40'd24, 0, 1'b0);
        run({32'($urandom), 8'd23}, 5, 1'b0);

        // Node-table write during WALK must be dropped.
        run({32'($urandom), 8'd23}, 0, 1'b1);
        run({32'($urandom), 8'd23}, 1, 1'b0);

        cfg_write(0, mk_int(0, 0, 255, 1, 2));
        run({32'($urandom), 8'd255}, 0, 1'b0);
        cfg_write(0, mk_int(0, 0, 254, 1, 2));
        run({32'($urandom), 8'd255}, 0, 1'b0);
        cfg_write(0, mk_int(7, 0, 0, 1, 2));
        run({32'hFFFF_FFFF, 8'hFF}, 2, 1'b0);

        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 64; a++) begin
                if ($urandom_range(0, 2) == 0)
                    cfg_write(a, mk_leaf(int'($urandom_range(0, 63))));
                else
                    cfg_write(a, mk_int(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                                        int'($urandom_range(0, 63))));
            end
            for (int k = 0; k < 15; k++) begin
                logic [39:0] f;
                f = {$urandom, 8'($urandom)};
                if (k % 5 == 0) f = '1;
                if (k % 5 == 1) f = '0;
                run(f, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        // Reset mid-WALK: abort, outputs cleared at once, table cleared.
        cfg_write(0, mk_int(0, 0, 255, 0, 0));
        in_feat  = 40'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midwalk_rst_busy", int'(busy), 0);
        chk("midwalk_rst_out_valid", int'(out_valid), 0);
        chk("midwalk_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_tbl[i] = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        run({$urandom, 8'($urandom)}, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
